// File: rtl/keypad_pkg.sv
// Shared keypad event types and helpers.
// Event word is {rel, code}; lsb_index picks the lowest pending key.
package keypad_pkg;

   localparam int KEY_N  = 16;
   localparam int CODE_W = 4;
   localparam int EVT_W  = 5;

   typedef struct packed {
      logic              rel;
      logic [CODE_W-1:0] code;
   } evt_t;

   // Scan from the top so the last hit is the lowest set bit
   function automatic logic [CODE_W-1:0] lsb_index(input logic [KEY_N-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = KEY_N - 1; i >= 0; i--) begin
         if (v[i]) idx = CODE_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/kp_sync_fifo.sv
// Show-ahead synchronous FIFO with a separate occupancy counter.
// Head visible in the cycle after a write; a write to a full FIFO is taken only together with a pop.
module kp_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int EVT_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_flush,
   input  logic             i_push_vld,
   input  logic [EVT_W-1:0] i_push_dat,
   input  logic             i_pop_rdy,
   output logic [EVT_W-1:0] o_rd_dat,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   logic [EVT_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;

   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = i_pop_rdy & ~w_empty & ~i_flush;
   assign w_push  = i_push_vld & (~w_full | w_pop) & ~i_flush;

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_push_dat;
   end

   assign o_rd_dat = w_empty ? '0 : r_mem[r_rptr];
   assign o_full   = w_full;
   assign o_empty  = w_empty;
   assign o_count  = r_count;

endmodule

// File: rtl/keypad_event_fifo.sv
// Keypad level vector -> queued key-code events (1-cycle edge-to-rd_valid), valid/ready drain, held when full.
// Release events only with KEYPAD_RELEASE_EVT_EN defined; otherwise falling edges are ignored.
module keypad_event_fifo
   import keypad_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [KEY_N-1:0] key_state,
   input  logic             flush,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [EVT_W-1:0] rd_data,
   output logic [AW:0]      count,
   input  logic             ovf_clr,
   output logic             overflow,
   output logic             irq
);

   logic [KEY_N-1:0] r_prev;
   logic [KEY_N-1:0] r_pend_p;
   logic             r_overflow;

   logic [KEY_N-1:0] w_press;
   logic [KEY_N-1:0] w_cand_p;
   logic [KEY_N-1:0] w_cand_r;
   logic [KEY_N-1:0] w_sel_oh;
   logic [KEY_N-1:0] w_clr_p;
   logic             w_ovf_evt;
   logic             w_sel_vld;
   evt_t             w_sel;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;

   assign w_press  = key_state & ~r_prev;
   assign w_cand_p = r_pend_p | w_press;

`ifdef KEYPAD_RELEASE_EVT_EN
   logic [KEY_N-1:0] r_pend_r;
   logic [KEY_N-1:0] w_rel;
   logic [KEY_N-1:0] w_clr_r;

   assign w_rel     = ~key_state & r_prev;
   assign w_cand_r  = r_pend_r | w_rel;
   assign w_clr_r   = (w_push && w_sel.rel) ? w_sel_oh : '0;
   assign w_ovf_evt = (|(w_press & r_pend_p)) | (|(w_rel & r_pend_r));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      r_pend_r <= '0;
      else if (flush) r_pend_r <= '0;
      else            r_pend_r <= w_cand_r & ~w_clr_r;
   end
`else
   assign w_cand_r  = '0;
   assign w_ovf_evt = |(w_press & r_pend_p);
`endif

   // Presses always win over releases; lowest code first within each class
   always_comb begin
      w_sel_vld = 1'b0;
      w_sel     = '0;
      if (|w_cand_p) begin
         w_sel_vld = 1'b1;
         w_sel.rel = 1'b0;
         w_sel.code = lsb_index(w_cand_p);
      end else if (|w_cand_r) begin
         w_sel_vld = 1'b1;
         w_sel.rel = 1'b1;
         w_sel.code = lsb_index(w_cand_r);
      end
   end

   always_comb begin
      w_sel_oh = '0;
      w_sel_oh[w_sel.code] = 1'b1;
   end

   assign w_pop   = ~w_empty & rd_ready;
   assign w_push  = w_sel_vld & (~w_full | w_pop) & ~flush;
   assign w_clr_p = (w_push && !w_sel.rel) ? w_sel_oh : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_prev     <= '0;
         r_pend_p   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_prev <= key_state;
         if (flush) begin
            r_pend_p <= '0;
         end else begin
            r_pend_p <= w_cand_p & ~w_clr_p;
            if (w_ovf_evt)    r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
         end
      end
   end

   kp_sync_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .EVT_W (EVT_W)
   ) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .i_flush    (flush),
      .i_push_vld (w_push),
      .i_push_dat (w_sel),
      .i_pop_rdy  (rd_ready),
      .o_rd_dat   (rd_data),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (count)
   );

   assign rd_valid = ~w_empty;
   assign irq      = ~w_empty;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Directed stimulus with a queue-based scoreboard checked on every read handshake.
module tb_keypad_event_fifo;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] key_state = '0;
   logic        flush = 1'b0;
   logic        rd_ready = 1'b0;
   logic        rd_valid;
   logic [4:0]  rd_data;
   logic [3:0]  count;
   logic        ovf_clr = 1'b0;
   logic        overflow;
   logic        irq;

   logic [4:0]  exp_q[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   keypad_event_fifo #(.DEPTH(8), .AW(3)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .key_state (key_state),
      .flush     (flush),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .count     (count),
      .ovf_clr   (ovf_clr),
      .overflow  (overflow),
      .irq       (irq)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Scoreboard monitor: every accepted read must match the queue head
   always @(negedge clk) begin
      if (rstn && rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected actual=%0h required=none", rd_data);
         end else begin
            chk("pop_data", {27'd0, rd_data}, {27'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      key_state = '0;
      flush     = 1'b0;
      rd_ready  = 1'b0;
      ovf_clr   = 1'b0;
      rstn      = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic drain(input string nm);
      bit done;
      done = 1'b0;
      rd_ready = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!rd_valid) done = 1'b1;
         else tick();
      end
      rd_ready = 1'b0;
      chk({nm, "_left"}, exp_q.size(), 0);
      chk({nm, "_count"}, {28'd0, count}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rstn = 1'b0;
      tick();
      chk("rst_valid", rd_valid, 0);
      chk("rst_data", {27'd0, rd_data}, 0);
      chk("rst_count", {28'd0, count}, 0);
      chk("rst_irq", irq, 0);
      chk("rst_ovf", overflow, 0);
      rstn = 1'b1;
      tick();

      // T1: single press, one-cycle latency
      key_state = 16'h0010;
      exp_q.push_back(5'h04);
      tick();
      chk("t1_valid", rd_valid, 1);
      chk("t1_data", {27'd0, rd_data}, 32'h04);
      chk("t1_count", {28'd0, count}, 1);
      chk("t1_irq", irq, 1);
      drain("t1");

      // T2: simultaneous presses queued in ascending order
      do_reset();
      key_state = 16'h8009;
      exp_q.push_back(5'h00);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h0F);
      tick();
      chk("t2_count1", {28'd0, count}, 1);
      chk("t2_head", {27'd0, rd_data}, 0);
      tick();
      tick();
      chk("t2_count3", {28'd0, count}, 3);
      tick();
      chk("t2_count_hold", {28'd0, count}, 3);
      drain("t2");

      // T3: full FIFO, repeated edge on key 2 while pending -> overflow
      do_reset();
      key_state = 16'h00FF;
      for (int k = 0; k < 8; k++) exp_q.push_back(5'(k));
      repeat (8) tick();
      chk("t3_full", {28'd0, count}, 8);
      key_state = 16'h00FB; tick();
      key_state = 16'h00FF; tick();
      chk("t3_no_ovf_yet", overflow, 0);
      key_state = 16'h00FB; tick();
      key_state = 16'h00FF; tick();
      chk("t3_ovf", overflow, 1);
      chk("t3_count", {28'd0, count}, 8);
      exp_q.push_back(5'h02);
`ifdef KEYPAD_RELEASE_EVT_EN
      exp_q.push_back(5'h12);
`endif
      drain("t3");
      chk("t3_ovf_sticky", overflow, 1);

      // T5: flush beats ovf_clr, leaves overflow alone
      key_state = 16'h07FF;
      exp_q.push_back(5'h08);
      exp_q.push_back(5'h09);
      exp_q.push_back(5'h0A);
      repeat (3) tick();
      chk("t5_count3", {28'd0, count}, 3);
      flush = 1'b1;
      ovf_clr = 1'b1;
      tick();
      flush = 1'b0;
      ovf_clr = 1'b0;
      exp_q.delete();
      chk("t5_valid", rd_valid, 0);
      chk("t5_count", {28'd0, count}, 0);
      chk("t5_data", {27'd0, rd_data}, 0);
      chk("t5_ovf", overflow, 1);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      chk("t5_empty_read", {28'd0, count}, 0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t5_ovf_clr", overflow, 0);

      // T4: full + read + pending -> count held at 8 while pending drains
      do_reset();
      key_state = 16'h00FF;
      for (int k = 0; k < 12; k++) exp_q.push_back(5'(k));
      repeat (8) tick();
      key_state = 16'h0FFF;
      tick();
      chk("t4_full_pend", {28'd0, count}, 8);
      rd_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t4_count_hold", {28'd0, count}, 8);
      end
      tick();
      chk("t4_count7", {28'd0, count}, 7);
      drain("t4");
      chk("t4_ovf", overflow, 0);

      // T6: press then release of key 5, then reset mid-queue
      do_reset();
      key_state = 16'h0020;
      exp_q.push_back(5'h05);
      tick();
      key_state = 16'h0000;
`ifdef KEYPAD_RELEASE_EVT_EN
      exp_q.push_back(5'h15);
`endif
      tick();
      tick();
      chk("t6_count", {28'd0, count}, 32'(exp_q.size()));
      chk("t6_head", {27'd0, rd_data}, 32'h05);
      rstn = 1'b0;
      #2;
      chk("t6_rst_valid", rd_valid, 0);
      chk("t6_rst_data", {27'd0, rd_data}, 0);
      chk("t6_rst_count", {28'd0, count}, 0);
      chk("t6_rst_irq", irq, 0);
      exp_q.delete();
      tick();
      rstn = 1'b1;
      tick();
      chk("t6_after_rst", rd_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
